// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute and drives datapath selects and enables.
// Latency: lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2 cycles with mem_ready held high.
// Backpressure: FETCH, MEMREAD and MEMWRITE stall while mem_ready is low; every other state advances each cycle.
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   op[6:0], zero, mem_ready      opcode, ALU zero flag, memory handshake
//   pc_write, ir_write, mem_write, reg_write, illegal        enables / pulses
//   adr_src, result_src, alu_src_a, alu_src_b, imm_src, alu_op datapath selects
module multicycle_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic       reg_write,
   output logic [1:0] alu_op,
   output logic       illegal
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OpLw   = 7'd3;
   localparam logic [6:0] OpSw   = 7'd35;
   localparam logic [6:0] OpRtyp = 7'd51;
   localparam logic [6:0] OpItyp = 7'd19;
   localparam logic [6:0] OpBeq  = 7'd99;
   localparam logic [6:0] OpJal  = 7'd111;

   state_t state, stateNext;

   // Unstrobed enables from the state decode; gated by rst below.
   logic pcWriteRaw, memWriteRaw, irWriteRaw, regWriteRaw, illegalRaw;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext   = state;
      pcWriteRaw  = 1'b0;
      memWriteRaw = 1'b0;
      irWriteRaw  = 1'b0;
      regWriteRaw = 1'b0;
      illegalRaw  = 1'b0;
      adr_src     = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;

      case (state)
         FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            irWriteRaw = mem_ready;
            pcWriteRaw = mem_ready;
            if (mem_ready) stateNext = DECODE;
         end
         DECODE: begin
            // Precompute the branch/jump target into ALUOut.
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               OpLw, OpSw: stateNext = MEMADR;
               OpRtyp:     stateNext = EXECUTER;
               OpItyp:     stateNext = EXECUTEI;
               OpBeq:      stateNext = BEQ;
               OpJal:      stateNext = JAL;
               default: begin
                  stateNext  = FETCH;
                  illegalRaw = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            stateNext = (op == OpLw) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            adr_src = 1'b1;
            if (mem_ready) stateNext = MEMWB;
         end
         MEMWB: begin
            result_src  = 2'b01;
            regWriteRaw = 1'b1;
            stateNext   = FETCH;
         end
         MEMWRITE: begin
            // Strobe stays up through the cycle memory accepts the write.
            adr_src     = 1'b1;
            memWriteRaw = 1'b1;
            if (mem_ready) stateNext = FETCH;
         end
         EXECUTER: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            stateNext = ALUWB;
         end
         EXECUTEI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            stateNext = ALUWB;
         end
         ALUWB: begin
            regWriteRaw = 1'b1;
            stateNext   = FETCH;
         end
         BEQ: begin
            alu_src_a  = 2'b10;
            alu_op     = 2'b01;
            pcWriteRaw = zero;
            stateNext  = FETCH;
         end
         JAL: begin
            // PC <= target held in ALUOut while the ALU forms old PC + 4 for rd.
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            pcWriteRaw = 1'b1;
            stateNext  = ALUWB;
         end
         default: stateNext = FETCH;
      endcase
   end

   // State is already FETCH while rst is high, but FETCH's enables follow
   // mem_ready, so all strobes are forced low for the whole reset interval.
   always_comb begin
      pc_write  = pcWriteRaw  & ~rst;
      ir_write  = irWriteRaw  & ~rst;
      mem_write = memWriteRaw & ~rst;
      reg_write = regWriteRaw & ~rst;
      illegal   = illegalRaw  & ~rst;
   end

   always_comb begin
      case (op)
         OpSw:    imm_src = 2'b01;
         OpBeq:   imm_src = 2'b10;
         OpJal:   imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes hand-derived output vectors per cycle,
// a negedge monitor pops and compares the packed DUT outputs.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, alu_op;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
      .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_write(reg_write),
      .alu_op(alu_op), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] v;
      string       name;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;

   // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, imm_src, reg_write, alu_op, illegal}
   function automatic logic [15:0] pack(logic pcw, logic adr, logic mw, logic irw, logic [1:0] rs,
                                        logic [1:0] a, logic [1:0] b, logic [1:0] imm,
                                        logic rw, logic [1:0] aop, logic ill);
      return {pcw, adr, mw, irw, rs, a, b, imm, rw, aop, ill};
   endfunction

   function automatic logic [15:0] fetchV(logic mr, logic [1:0] imm);
      return pack(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, imm, 0, 2'b00, 0);
   endfunction
   function automatic logic [15:0] decodeV(logic [1:0] imm, logic ill);
      return pack(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 0, 2'b00, ill);
   endfunction
   function automatic logic [15:0] memadrV(logic [1:0] imm);
      return pack(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 0, 2'b00, 0);
   endfunction
   function automatic logic [15:0] memreadV();
      return pack(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);
   endfunction
   function automatic logic [15:0] memwbV();
      return pack(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0);
   endfunction
   function automatic logic [15:0] memwriteV();
      return pack(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 2'b00, 0);
   endfunction
   function automatic logic [15:0] execRV();
      return pack(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 2'b10, 0);
   endfunction
   function automatic logic [15:0] execIV();
      return pack(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 2'b10, 0);
   endfunction
   function automatic logic [15:0] aluwbV(logic [1:0] imm);
      return pack(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 1, 2'b00, 0);
   endfunction
   function automatic logic [15:0] beqV(logic z);
      return pack(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 2'b01, 0);
   endfunction
   function automatic logic [15:0] jalV();
      return pack(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 0, 2'b00, 0);
   endfunction

   // One cycle of stimulus: drive inputs just after the edge, queue the expected outputs.
   task automatic step(input logic r, input logic [6:0] o, input logic z, input logic mr,
                       input logic [15:0] e, input string name);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r; op = o; zero = z; mem_ready = mr;
      x.v = e; x.name = name;
      expQ.push_back(x);
   endtask

   // Assert reset mid-cycle, after the current cycle's outputs have been sampled.
   task automatic midReset();
      @(negedge clk);
      #2;
      rst = 1'b1;
   endtask

   // Monitor: compares DUT outputs against the scoreboard away from the active edge.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         exp_t e;
         logic [15:0] act;
         e   = expQ.pop_front();
         act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                imm_src, reg_write, alu_op, illegal};
         total++;
         if (act !== e.v) begin
            bad++;
            $display("FAIL %s: got %b expected %b (pcw adr mw irw rs a b imm rw aop ill)",
                     e.name, act, e.v);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; op = 7'd51; zero = 1'b0; mem_ready = 1'b1;

      // Reset held with mem_ready high: FETCH selects, all enables low.
      step(1, 7'd51, 0, 1, fetchV(0, 2'b00), "reset_hold");
      step(1, 7'd51, 0, 1, fetchV(0, 2'b00), "reset_hold2");

      // R-type
      step(0, 7'd51, 0, 1, fetchV(1, 2'b00), "r_fetch");
      step(0, 7'd51, 0, 1, decodeV(2'b00, 0), "r_decode");
      step(0, 7'd51, 0, 1, execRV(),          "r_execr");
      step(0, 7'd51, 0, 1, aluwbV(2'b00),     "r_aluwb");

      // I-type
      step(0, 7'd19, 0, 1, fetchV(1, 2'b00), "i_fetch");
      step(0, 7'd19, 0, 1, decodeV(2'b00, 0), "i_decode");
      step(0, 7'd19, 0, 1, execIV(),          "i_execi");
      step(0, 7'd19, 0, 1, aluwbV(2'b00),     "i_aluwb");

      // lw with 3 wait cycles in MEMREAD
      step(0, 7'd3, 0, 1, fetchV(1, 2'b00),  "lw_fetch");
      step(0, 7'd3, 0, 1, decodeV(2'b00, 0), "lw_decode");
      step(0, 7'd3, 0, 1, memadrV(2'b00),    "lw_memadr");
      step(0, 7'd3, 0, 0, memreadV(),        "lw_memread_w1");
      step(0, 7'd3, 0, 0, memreadV(),        "lw_memread_w2");
      step(0, 7'd3, 0, 0, memreadV(),        "lw_memread_w3");
      step(0, 7'd3, 0, 1, memreadV(),        "lw_memread_done");
      step(0, 7'd3, 0, 1, memwbV(),          "lw_memwb");

      // sw with FETCH stall, then 2 wait cycles in MEMWRITE
      step(0, 7'd35, 0, 0, fetchV(0, 2'b01),  "sw_fetch_stall1");
      step(0, 7'd35, 0, 0, fetchV(0, 2'b01),  "sw_fetch_stall2");
      step(0, 7'd35, 0, 1, fetchV(1, 2'b01),  "sw_fetch");
      step(0, 7'd35, 0, 1, decodeV(2'b01, 0), "sw_decode");
      step(0, 7'd35, 0, 1, memadrV(2'b01),    "sw_memadr");
      step(0, 7'd35, 0, 0, memwriteV(),       "sw_memwrite_w1");
      step(0, 7'd35, 0, 0, memwriteV(),       "sw_memwrite_w2");
      step(0, 7'd35, 0, 1, memwriteV(),       "sw_memwrite_done");

      // beq taken then not taken
      step(0, 7'd99, 1, 1, fetchV(1, 2'b10),  "beq1_fetch");
      step(0, 7'd99, 1, 1, decodeV(2'b10, 0), "beq1_decode");
      step(0, 7'd99, 1, 1, beqV(1),           "beq_taken");
      step(0, 7'd99, 0, 1, fetchV(1, 2'b10),  "beq0_fetch");
      step(0, 7'd99, 0, 1, decodeV(2'b10, 0), "beq0_decode");
      step(0, 7'd99, 0, 1, beqV(0),           "beq_not_taken");

      // Illegal opcode: one-cycle pulse in DECODE, back to FETCH
      step(0, 7'h7F, 0, 1, fetchV(1, 2'b00),  "ill_fetch");
      step(0, 7'h7F, 0, 1, decodeV(2'b00, 1), "ill_decode");
      step(0, 7'h7F, 0, 0, fetchV(0, 2'b00),  "ill_back_fetch");

      // jal, reset asserted during JAL
      step(0, 7'd111, 0, 1, fetchV(1, 2'b11),  "jal_fetch");
      step(0, 7'd111, 0, 1, decodeV(2'b11, 0), "jal_decode");
      step(0, 7'd111, 0, 1, jalV(),            "jal_jal");
      midReset();
      step(1, 7'd111, 0, 1, fetchV(0, 2'b11),  "jal_reset_hold");
      step(0, 7'd111, 0, 1, fetchV(1, 2'b11),  "jal_after_reset_fetch");
      step(0, 7'd111, 0, 1, decodeV(2'b11, 0), "jal_after_reset_decode");
      step(0, 7'd111, 0, 1, jalV(),            "jal2_jal");
      step(0, 7'd111, 0, 1, aluwbV(2'b11),     "jal2_aluwb");

      // sw aborted by reset while waiting in MEMWRITE
      step(0, 7'd35, 0, 1, fetchV(1, 2'b01),  "swr_fetch");
      step(0, 7'd35, 0, 1, decodeV(2'b01, 0), "swr_decode");
      step(0, 7'd35, 0, 1, memadrV(2'b01),    "swr_memadr");
      step(0, 7'd35, 0, 0, memwriteV(),       "swr_memwrite_w1");
      midReset();
      step(1, 7'd35, 0, 0, fetchV(0, 2'b01),  "swr_reset_hold");
      step(0, 7'd35, 0, 0, fetchV(0, 2'b01),  "swr_after_fetch_stall");
      step(0, 7'd35, 0, 1, fetchV(1, 2'b01),  "swr_after_fetch");
      step(0, 7'd35, 0, 1, decodeV(2'b01, 0), "swr_after_decode");

      // Drain the scoreboard; a leftover entry means the monitor lost cycles.
      repeat (3) @(posedge clk);
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
